// File: rtl/fractal_sync_root.sv
// Root responder of a fractal synchronization tree: joins IN_PORTS subtrees on
// barrier IDs tracked in a small CAM and returns wake or error pulses per port.
module fractal_sync_root #(
    parameter int IN_PORTS   = 2,
    parameter int AGGR_WIDTH = 7,
    parameter int ID_WIDTH   = 6,
    parameter int SRC_WIDTH  = 4,
    parameter int N_ENTRIES  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [IN_PORTS-1:0]               req_sync_i,
    input  logic [IN_PORTS*AGGR_WIDTH-1:0]    req_aggr_i,
    input  logic [IN_PORTS*ID_WIDTH-1:0]      req_id_i,
    input  logic [IN_PORTS*SRC_WIDTH-1:0]     req_src_i,
    output logic [IN_PORTS-1:0]               rsp_wake_o,
    output logic [IN_PORTS-1:0]               rsp_error_o,
    output logic [IN_PORTS*SRC_WIDTH-1:0]     rsp_dst_o,
    output logic [$clog2(N_ENTRIES+1)-1:0]    pending_o,
    output logic                              err_drop_o
);

    localparam int PW  = $clog2(N_ENTRIES+1);
    localparam int SPW = IN_PORTS*SRC_WIDTH;

    logic [N_ENTRIES-1:0] cam_valid;
    logic [N_ENTRIES-1:0] nxt_valid;
    logic [N_ENTRIES-1:0] fin_valid;
    logic [ID_WIDTH-1:0]  cam_id  [N_ENTRIES];
    logic [ID_WIDTH-1:0]  nxt_id  [N_ENTRIES];
    logic [IN_PORTS-1:0]  cam_arr [N_ENTRIES];
    logic [IN_PORTS-1:0]  nxt_arr [N_ENTRIES];
    logic [SPW-1:0]       cam_src [N_ENTRIES];
    logic [SPW-1:0]       nxt_src [N_ENTRIES];

    logic [IN_PORTS-1:0]  err_new;
    logic                 cmp_hit;
    logic [SPW-1:0]       cmp_src;
    logic [PW-1:0]        cnt;

    logic [IN_PORTS-1:0]  hold_vld;
    logic [IN_PORTS-1:0]  hold_vld_n;
    logic [IN_PORTS-1:0]  hold_load;
    logic [SRC_WIDTH-1:0] hold_dst [IN_PORTS];
    logic [IN_PORTS-1:0]  err_n;
    logic [SPW-1:0]       dst_n;
    logic                 drop_n;

    // Request pass: ports are applied in order to a working copy of the CAM, so
    // a later port sees entries allocated or updated by an earlier one.
    always_comb begin : pass
        logic                 hit;
        logic                 free;
        int                   hidx;
        int                   fidx;
        logic [ID_WIDTH-1:0]  id;
        logic [SRC_WIDTH-1:0] src;
        nxt_valid = cam_valid;
        nxt_id    = cam_id;
        nxt_arr   = cam_arr;
        nxt_src   = cam_src;
        err_new   = '0;
        for (int p = 0; p < IN_PORTS; p++) begin
            id   = req_id_i[p*ID_WIDTH +: ID_WIDTH];
            src  = req_src_i[p*SRC_WIDTH +: SRC_WIDTH];
            hit  = 1'b0;
            free = 1'b0;
            hidx = 0;
            fidx = 0;
            for (int e = 0; e < N_ENTRIES; e++) begin
                if (!hit && nxt_valid[e] && nxt_id[e] == id) begin
                    hit  = 1'b1;
                    hidx = e;
                end
                if (!free && !nxt_valid[e]) begin
                    free = 1'b1;
                    fidx = e;
                end
            end
            if (req_sync_i[p]) begin
                if (req_aggr_i[p*AGGR_WIDTH +: AGGR_WIDTH] != AGGR_WIDTH'(1)) begin
                    err_new[p] = 1'b1;
                end else if (hit) begin
                    if (nxt_arr[hidx][p]) begin
                        err_new[p] = 1'b1;
                    end else begin
                        nxt_arr[hidx][p] = 1'b1;
                        nxt_src[hidx][p*SRC_WIDTH +: SRC_WIDTH] = src;
                    end
                end else if (free) begin
                    nxt_valid[fidx] = 1'b1;
                    nxt_id[fidx]    = id;
                    nxt_arr[fidx]   = '0;
                    nxt_arr[fidx][p] = 1'b1;
                    nxt_src[fidx][p*SRC_WIDTH +: SRC_WIDTH] = src;
                end else begin
                    err_new[p] = 1'b1;
                end
            end
        end
    end

    // One completion per cycle (lowest index); any other complete entry stays
    // valid with all arrivals set and retires on a following cycle.
    always_comb begin : complete
        cmp_hit   = 1'b0;
        cmp_src   = '0;
        fin_valid = nxt_valid;
        for (int e = 0; e < N_ENTRIES; e++) begin
            if (!cmp_hit && nxt_valid[e] && (&nxt_arr[e])) begin
                cmp_hit      = 1'b1;
                cmp_src      = nxt_src[e];
                fin_valid[e] = 1'b0;
            end
        end
        cnt = '0;
        for (int e = 0; e < N_ENTRIES; e++) begin
            cnt = cnt + PW'(fin_valid[e]);
        end
    end

    // Response arbitration: a wake always wins; a displaced error parks in the
    // 1-deep holding register and is lost only if that register is occupied.
    always_comb begin : respond
        drop_n     = 1'b0;
        hold_vld_n = '0;
        hold_load  = '0;
        err_n      = '0;
        dst_n      = '0;
        for (int p = 0; p < IN_PORTS; p++) begin
            hold_load[p] = err_new[p] && (cmp_hit != hold_vld[p]);
            if (cmp_hit) begin
                drop_n        = drop_n | (err_new[p] & hold_vld[p]);
                hold_vld_n[p] = hold_vld[p] | err_new[p];
                dst_n[p*SRC_WIDTH +: SRC_WIDTH] = cmp_src[p*SRC_WIDTH +: SRC_WIDTH];
            end else if (hold_vld[p]) begin
                hold_vld_n[p] = err_new[p];
                err_n[p]      = 1'b1;
                dst_n[p*SRC_WIDTH +: SRC_WIDTH] = hold_dst[p];
            end else if (err_new[p]) begin
                err_n[p] = 1'b1;
                dst_n[p*SRC_WIDTH +: SRC_WIDTH] = req_src_i[p*SRC_WIDTH +: SRC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cam_valid   <= '0;
            for (int e = 0; e < N_ENTRIES; e++) begin
                cam_arr[e] <= '0;
            end
            hold_vld    <= '0;
            rsp_wake_o  <= '0;
            rsp_error_o <= '0;
            rsp_dst_o   <= '0;
            pending_o   <= '0;
            err_drop_o  <= 1'b0;
        end else begin
            cam_valid   <= fin_valid;
            cam_arr     <= nxt_arr;
            hold_vld    <= hold_vld_n;
            rsp_wake_o  <= {IN_PORTS{cmp_hit}};
            rsp_error_o <= err_n;
            rsp_dst_o   <= dst_n;
            pending_o   <= cnt;
            err_drop_o  <= err_drop_o | drop_n;
        end
    end

    always_ff @(posedge clk_i) begin
        cam_id  <= nxt_id;
        cam_src <= nxt_src;
        for (int p = 0; p < IN_PORTS; p++) begin
            if (hold_load[p]) begin
                hold_dst[p] <= req_src_i[p*SRC_WIDTH +: SRC_WIDTH];
            end
        end
    end

endmodule

// File: doc/fractal_sync_root.md
Name: fractal_sync_root

Overview:
- Synthesizable responder that terminates the top of a fractal synchronization tree; it is the far end of a fractal_sync node's output (req_out/rsp_out) ports.
- Accepts barrier requests from IN_PORTS subtrees and tracks pending barriers per ID in a small CAM.
- When every port has arrived on the same barrier ID, it returns a one-cycle wake to each port, with dst set to that port's recorded source.
- Malformed requests, duplicate arrivals and CAM overflow return error responses.

Parameters:
IN_PORTS, 2, number of subtree ports joined at the root (>=2)
AGGR_WIDTH, 7, width of aggregate field
ID_WIDTH, 6, width of barrier ID field
SRC_WIDTH, 4, width of source/destination tag
N_ENTRIES, 4, pending-barrier CAM depth

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_sync_i  in  IN_PORTS  per-port request strobe, single-cycle pulse, no backpressure
req_aggr_i  in  IN_PORTS*AGGR_WIDTH  per-port aggregate
req_id_i  in  IN_PORTS*ID_WIDTH  per-port barrier ID
req_src_i  in  IN_PORTS*SRC_WIDTH  per-port source tag
rsp_wake_o  out  IN_PORTS  per-port wake pulse
rsp_error_o  out  IN_PORTS  per-port error pulse
rsp_dst_o  out  IN_PORTS*SRC_WIDTH  per-port destination tag, valid with wake or error
pending_o  out  $clog2(N_ENTRIES+1)  number of occupied CAM entries
err_drop_o  out  1  sticky, an error response was lost

Behaviour:
- Reset (async, rst_ni=0): all CAM entries invalid; rsp_wake_o, rsp_error_o, rsp_dst_o, pending_o and err_drop_o all 0; error holding registers empty. A barrier in progress is discarded.
- A request on port p is well-formed iff req_aggr_i[p] == 1, i.e. only bit 0 is set (the sync terminates at the root level). Any other value is an error for port p.
- CAM entry fields: valid, id, arrived[IN_PORTS], src[IN_PORTS][SRC_WIDTH].
- Per cycle, requests are processed in one combinational pass, port 0 first:
  - Same-cycle requests with equal IDs are merged.
  - Each well-formed request matches the valid entry with the same ID.
  - If arrived[p] is already set, port p gets an error (duplicate). The entry is unchanged.
  - Otherwise set arrived[p] and store src[p].
  - If no entry matches, allocate the lowest-index invalid entry.
  - If the CAM is full, port p gets an error and nothing is allocated.
- Completion: when arrived is all-ones, including the case where all ports arrive in the same cycle with no entry ever allocated:
  - Next cycle, rsp_wake_o[q]=1 and rsp_dst_o[q]=src[q] for every q.
  - The entry is freed in that same cycle.
- Latency: request at cycle N gives its response at cycle N+1. All outputs are registered; pulses last exactly one cycle.
- Response collisions:
  - A port may need a wake and an error in the same cycle. Wake wins; the error (with dst = offending req_src) goes to that port's 1-deep holding register.
  - The held error is emitted on the first later cycle with no wake on that port.
  - If the holding register is already full, the new error is dropped and err_drop_o is set. err_drop_o stays 1 until reset.
- Error responses use dst = req_src_i of the offending request.
- The freed entry is visible for allocation in the cycle after completion.
- pending_o equals the count of valid entries, registered.
- A wake and an error are never asserted on the same port in the same cycle.

Test Plan:
- Reset, then port0 id=5 src=2 at cycle 10 and port1 id=5 src=3 at cycle 40 -> pending_o=1 during cycles 11-40; at cycle 41 wake on both ports, dst0=2, dst1=3; pending_o=0.
- Both ports id=0 aggr=1 in the same cycle -> both wakes exactly 1 cycle later, no CAM entry allocated.
- Port0 aggr=3 src=7 -> rsp_error_o[0]=1 with dst=7 next cycle; no wake; pending_o unchanged.
- Port0 sends id=9 twice before port1 arrives -> second request gets error; port1 id=9 then gives wakes with dst0 from the first request.
- Port0 sends ids 1,2,3,4, then id=5 -> pending_o=4; id=5 errors; after port1 completes id=1, a new port0 id=5 allocates successfully.
- Port0 sends a duplicate id in the same cycle port1 completes the barrier -> port0 wake at N+1 and the held error at N+2; rsp_wake_o[0] and rsp_error_o[0] are never high together; assert rst_ni mid-barrier -> all outputs 0 and pending_o=0.
